serial_subtractor_16: RTL and testbench

Bit-serial subtractor computing `diff = a - b - bin`, one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse-direction companion to the combinational `sixteenBitAdder`. A bench can feed `diff`, `b` and `bin` back through the adder and require `sum == a`. It trades the adder's single-cycle ripple path for a WIDTH-cycle sequential datapath with one full-subtractor cell.

---
 rtl/serial_subtractor_16.sv | 118 +++++++++++
 tb/tb_serial_subtractor_16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16.sv
// serial_subtractor_16: bit-serial subtractor computing diff = a - b - bin,
// one bit per clock, LSB first, using a single full-subtractor cell.
// A start/busy/done handshake frames each operation; diff/bo update only
// on completion, so partial results are never visible.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered signed
// overflow output `ovf`.
module serial_subtractor_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bo,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   // Full-subtractor cell working on the current LSBs and the borrow flop.
   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
   assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
   assign res_next = {d_bit, res_sr[WIDTH-1:1]};

   // Control FSM, operand/result shift registers and registered outputs.
   // NOTE: every register here is assigned with <= so all of them sample the
   // pre-edge values; blocking = would let later statements see updated state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bo     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               res_sr <= res_next;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br     <= br_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // Final (MSB) bit: publish the full result in one go.
                  diff  <= res_next;
                  bo    <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                  // Signed overflow: borrow into the MSB cell differs from
                  // the borrow out of it.
                  ovf   <= br ^ br_next;
`endif
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               // start is ignored here; it is sampled only in IDLE.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_16.sv
// Self-checking bench for serial_subtractor_16: directed vector table,
// randomized operands against an arithmetic model, and hand-written
// sequences for start-while-busy and mid-operation reset.
// Build with +define+SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_subtractor_16;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] diff;
   logic         bo;
   logic         busy;
   logic         done;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   serial_subtractor_16 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bo    (bo),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_SUB_OVF_EN
      ,.ovf  (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bo;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain wide arithmetic and signed range test.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                        output logic [W-1:0] md, output logic mbo, output logic movf);
      int ua, ub, sa, sb, sres;
      ua   = int'(ma);
      ub   = int'(mb);
      sa   = ma[W-1] ? ua - 65536 : ua;
      sb   = mb[W-1] ? ub - 65536 : ub;
      md   = W'(ua - ub - int'(mbin));
      mbo  = (ua < ub + int'(mbin));
      sres = sa - sb - int'(mbin);
      movf = (sres < -32768) || (sres > 32767);
   endtask

   // Runs one operation and observes a 40-cycle window starting at the
   // accepting edge. pulse_at >= 1 drives a one-cycle start with fresh
   // operands after edge E_pulse_at; rst_at >= 1 asserts reset after E_rst_at.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input int pulse_at, input int rst_at,
                        output int lat, output int busy_cyc, output int n_done,
                        output int busy_fall);
      int guard;
      lat = -1; busy_cyc = 0; n_done = 0; busy_fall = -1;
      guard = 0;
      while (busy === 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("idle_before_start", 32'(busy), 32'd0);
      a = ta; b = tb_; bin = tbin; start = 1'b1;
      @(posedge clk); #1;                       // edge E0
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      for (int k = 0; k < 40; k++) begin
         if (busy === 1'b1) busy_cyc++;
         else if (busy_fall < 0) busy_fall = k;
         if (done === 1'b1) begin
            n_done++;
            if (lat < 0) lat = k;
         end
         start = (k == pulse_at) ? 1'b1 : 1'b0;
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_diff", 32'(diff), 32'd0);
            check("rst_bo",   32'(bo),   32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
            check("rst_ovf",  32'(ovf),  32'd0);
`endif
            @(negedge clk);
            rst = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic [W-1:0] ta,
                                input logic [W-1:0] tb_, input logic tbin);
      logic [W-1:0] ed;
      logic         ebo, eovf;
      int lat, bc, nd, bf;
      model(ta, tb_, tbin, ed, ebo, eovf);
      do_op(ta, tb_, tbin, -1, -1, lat, bc, nd, bf);
      check({tag, "_diff"}, 32'(diff), 32'(ed));
      check({tag, "_bo"},   32'(bo),   32'(ebo));
      check({tag, "_addback"}, 32'(W'(diff + tb_ + W'(tbin))), 32'(ta));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"},  32'(ovf),  32'(eovf));
`endif
      check({tag, "_latency"}, 32'(lat), 32'(W));
      check({tag, "_ndone"},   32'(nd),  32'd1);
      check({tag, "_busy_cycles"}, 32'(bc), 32'(W + 1));
   endtask

   vec_t vecs[7];

   initial begin
      logic [W-1:0] ed, ra, rb;
      logic         ebo, eovf, rbin;
      int lat, bc, nd, bf;

      vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
      vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #1;
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_bo",   32'(bo),   32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset_ovf",  32'(ovf),  32'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, -1, -1, lat, bc, nd, bf);
         check($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
         check($sformatf("vec%0d_bo", i),   32'(bo),   32'(vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
         check($sformatf("vec%0d_ovf", i),  32'(ovf),  32'(vecs[i].ovf));
`endif
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
         check($sformatf("vec%0d_busy", i),    32'(bc),  32'(W + 1));
         check($sformatf("vec%0d_ndone", i),   32'(nd),  32'd1);
      end

      // Randomized operands against the model.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
         run_and_check($sformatf("rand%0d", i), ra, rb, rbin);
      end

      // start pulsed with new operands during cycle 5 of a busy operation.
      model(16'h1357, 16'h2468, 1'b1, ed, ebo, eovf);
      do_op(16'h1357, 16'h2468, 1'b1, 4, -1, lat, bc, nd, bf);
      check("busy_start_diff",    32'(diff), 32'(ed));
      check("busy_start_bo",      32'(bo),   32'(ebo));
      check("busy_start_ndone",   32'(nd),   32'd1);
      check("busy_start_fall",    32'(bf),   32'(W + 1));
      check("busy_start_latency", 32'(lat),  32'(W));

      // Reset on cycle 8 of an operation: immediate clear, no done afterwards.
      do_op(16'hABCD, 16'h0123, 1'b0, -1, 7, lat, bc, nd, bf);
      check("abort_ndone", 32'(nd),   32'd0);
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_diff",  32'(diff), 32'd0);

      // A fresh operation after reset completes normally.
      run_and_check("post_reset", 16'hABCD, 16'h0123, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
